// File: rtl/mb8_pkg.sv
// Shared definitions for the radix-8 Booth multiplier partial-sum accumulator.
// Contents: default widths/latency, accumulator FSM state enum, and the
// default result-queue entry layout {sum, ovf, beats}.
package mb8_pkg;

  localparam int unsigned MB8_LAT   = 2;
  localparam int unsigned MB8_PW    = 16;
  localparam int unsigned MB8_ACC_W = 24;
  localparam int unsigned MB8_CNT_W = 8;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  typedef struct packed {
    logic [MB8_ACC_W-1:0] sum;
    logic                 ovf;
    logic [MB8_CNT_W-1:0] beats;
  } res_entry_t;

endpackage

// File: rtl/mb8_res_fifo.sv
// Two-entry result queue. Entry 0 is always the head, so the head register
// directly drives the consumer-facing outputs.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_din  : write request and data (ignored when full without pop)
//   i_pop          : remove head (ignored when empty)
//   o_head         : head entry
//   o_full/o_empty : occupancy flags
module mb8_res_fifo
  import mb8_pkg::*;
#(
  parameter type T = res_entry_t
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  T     i_din,
  input  logic i_pop,
  output T     o_head,
  output logic o_full,
  output logic o_empty
);

  T           r_ent0;
  T           r_ent1;
  logic [1:0] r_cnt;
  logic       w_pop;

  assign w_pop   = i_pop && (r_cnt != 2'd0);
  assign o_head  = r_ent0;
  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ent0 <= '0;
      r_ent1 <= '0;
      r_cnt  <= '0;
    end else if (i_push && w_pop) begin
      // Simultaneous push/pop keeps occupancy; a full queue shifts and refills.
      if (r_cnt == 2'd2) begin
        r_ent0 <= r_ent1;
        r_ent1 <= i_din;
      end else begin
        r_ent0 <= i_din;
      end
    end else if (i_push) begin
      if (r_cnt == 2'd0) begin
        r_ent0 <= i_din;
        r_cnt  <= 2'd1;
      end else if (r_cnt == 2'd1) begin
        r_ent1 <= i_din;
        r_cnt  <= 2'd2;
      end
    end else if (w_pop) begin
      r_ent0 <= r_ent1;
      r_cnt  <= r_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/mb8_psum_acc.sv
// Partial-sum accumulator behind the 2-stage radix-8 Booth multiplier.
// Framing {valid,last} is delayed LAT cycles to line up with product; each
// frame's signed products are summed into an ACC_W accumulator (wrap or
// saturate) and the result is queued in a 2-entry valid/ready queue.
// Ports:
//   CLK, RST                   : clock, asynchronous active-low reset
//   in_valid, in_last, in_clr  : beat framing at the multiplier input; abort
//   product                    : multiplier output, LAT cycles behind framing
//   out_valid/out_ready        : result handshake
//   out_sum, out_ovf, out_beats: frame sum, overflow flag, beat count
//   drop_err                   : sticky, a result was lost to a full queue
//   busy                       : frame open or beat in flight
module mb8_psum_acc
  import mb8_pkg::*;
#(
  parameter int unsigned LAT   = MB8_LAT,
  parameter int unsigned PW    = MB8_PW,
  parameter int unsigned ACC_W = MB8_ACC_W,
  parameter int unsigned CNT_W = MB8_CNT_W,
  parameter int unsigned SAT   = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_clr,
  input  logic [PW-1:0]    product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_beats,
  output logic             drop_err,
  output logic             busy
);

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic             ovf;
    logic [CNT_W-1:0] beats;
  } entry_t;

  localparam logic [ACC_W-1:0] C_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] C_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [LAT-1:0]     r_vld;
  logic [LAT-1:0]     r_lst;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_ovf;
  logic               w_ovf_nxt;
  logic               r_drop_err;

  logic               w_v_d;
  logic               w_l_d;
  logic signed [PW-1:0] w_prod_s;
  logic [ACC_W-1:0]   w_sext;
  logic               w_open;
  logic [ACC_W-1:0]   w_acc_base;
  logic [CNT_W-1:0]   w_cnt_base;
  logic               w_ovf_base;
  logic [ACC_W-1:0]   w_add;
  logic               w_add_of;
  logic [ACC_W-1:0]   w_acc_new;
  logic [CNT_W-1:0]   w_cnt_new;
  logic               w_ovf_new;
  logic               w_push;
  entry_t             w_res;
  entry_t             w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;

  // Framing delay line; the beat presented with in_clr is dropped too.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_vld <= '0;
      r_lst <= '0;
    end else if (in_clr) begin
      r_vld <= '0;
      r_lst <= '0;
    end else begin
      r_vld[0] <= in_valid;
      r_lst[0] <= in_valid && in_last;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_lst[i] <= r_lst[i-1];
      end
    end
  end

  assign w_v_d    = r_vld[LAT-1];
  assign w_l_d    = r_lst[LAT-1];
  assign w_prod_s = product;
  assign w_sext   = ACC_W'(w_prod_s);

  // In IDLE the addend base is zero, so one adder serves both the first
  // beat of a frame and every later beat.
  always_comb begin
    w_open     = (r_state == ACCUM);
    w_acc_base = w_open ? r_acc : '0;
    w_cnt_base = w_open ? r_cnt : '0;
    w_ovf_base = w_open && r_ovf;
    w_add      = w_acc_base + w_sext;
    w_add_of   = (w_acc_base[ACC_W-1] == w_sext[ACC_W-1]) &&
                 (w_add[ACC_W-1] != w_acc_base[ACC_W-1]);
    w_acc_new  = ((SAT != 0) && w_add_of) ?
                 (w_acc_base[ACC_W-1] ? C_MIN : C_MAX) : w_add;
    w_cnt_new  = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_W'(1);
    w_ovf_new  = w_ovf_base || w_add_of;

    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_push      = 1'b0;
    w_res       = '{sum: w_acc_new, ovf: w_ovf_new, beats: w_cnt_new};

    if (in_clr) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end else if (w_v_d) begin
      if (w_l_d) begin
        w_push      = 1'b1;
        w_state_nxt = IDLE;
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
        w_ovf_nxt   = 1'b0;
      end else begin
        w_state_nxt = ACCUM;
        w_acc_nxt   = w_acc_new;
        w_cnt_nxt   = w_cnt_new;
        w_ovf_nxt   = w_ovf_new;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ovf      <= w_ovf_nxt;
      r_drop_err <= r_drop_err || (w_push && w_full && !w_pop);
    end
  end

  assign w_pop = out_valid && out_ready;

  mb8_res_fifo #(
    .T(entry_t)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_push  (w_push),
    .i_din   (w_res),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid = !w_empty;
  assign out_sum   = w_head.sum;
  assign out_ovf   = w_head.ovf;
  assign out_beats = w_head.beats;
  assign drop_err  = r_drop_err;
  assign busy      = (r_state == ACCUM) || (|r_vld);

endmodule

// File: tb/tb_mb8_psum_acc.sv
module tb_mb8_psum_acc;

  logic CLK = 1'b0;
  logic RST;
  logic in_valid, in_last, in_clr, out_ready;
  logic signed [7:0]  mx, my;
  logic signed [15:0] p0, p1;

  logic               v24, v16s, v16w;
  logic signed [23:0] s24;
  logic signed [15:0] s16s, s16w;
  logic               o24, o16s, o16w;
  logic [7:0]         b24, b16s, b16w;
  logic               d24, d16s, d16w;
  logic               busy24, busy16s, busy16w;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    longint s24, s16s, s16w;
    bit     o24, o16s, o16w;
    int     beats;
  } exp_t;
  exp_t exp_q[$];

  // Reference model frame state, one accumulator per DUT configuration.
  bit     m_open;
  longint m_a24, m_a16s, m_a16w;
  bit     m_o24, m_o16s, m_o16w;
  int     m_cnt;
  bit     m_drop_next;

  always #5 CLK = ~CLK;

  // Multiplier stand-in: product appears 2 cycles after the operands.
  always @(posedge CLK) begin
    p0 <= mx * my;
    p1 <= p0;
  end

  mb8_psum_acc u_dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_last(in_last), .in_clr(in_clr),
    .product(p1), .out_valid(v24), .out_ready(out_ready), .out_sum(s24),
    .out_ovf(o24), .out_beats(b24), .drop_err(d24), .busy(busy24)
  );

  mb8_psum_acc #(.ACC_W(16), .SAT(1)) u_sat16 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_last(in_last), .in_clr(in_clr),
    .product(p1), .out_valid(v16s), .out_ready(out_ready), .out_sum(s16s),
    .out_ovf(o16s), .out_beats(b16s), .drop_err(d16s), .busy(busy16s)
  );

  mb8_psum_acc #(.ACC_W(16), .SAT(0)) u_wrp16 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_last(in_last), .in_clr(in_clr),
    .product(p1), .out_valid(v16w), .out_ready(out_ready), .out_sum(s16w),
    .out_ovf(o16w), .out_beats(b16w), .drop_err(d16w), .busy(busy16w)
  );

  task automatic chk_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void acc_step(input longint acc, input longint p, input int w,
                                   input bit sat, output longint nacc, output bit of);
    longint s, mxv, mnv;
    mxv = (longint'(1) << (w - 1)) - 1;
    mnv = -(longint'(1) << (w - 1));
    s   = acc + p;
    of  = 1'b0;
    if (s > mxv || s < mnv) begin
      of = 1'b1;
      if (sat) s = (s > mxv) ? mxv : mnv;
      else begin
        s = s & ((longint'(1) << w) - 1);
        if (s > mxv) s = s - (longint'(1) << w);
      end
    end
    nacc = s;
  endfunction

  function automatic void model_reset();
    m_open = 0; m_a24 = 0; m_a16s = 0; m_a16w = 0;
    m_o24 = 0; m_o16s = 0; m_o16w = 0; m_cnt = 0;
  endfunction

  // Drive one beat for one cycle and update the model / scoreboard.
  task automatic drive_beat(input int a, input int b, input bit last, input bit clr);
    longint p;
    bit     of;
    exp_t   e;
    mx = 8'(a); my = 8'(b);
    in_valid = 1'b1; in_last = last; in_clr = clr;
    if (clr) model_reset();
    else begin
      p = longint'(a) * longint'(b);
      if (!m_open) model_reset();
      acc_step(m_a24, p, 24, 1'b0, m_a24, of);  m_o24  |= of;
      acc_step(m_a16s, p, 16, 1'b1, m_a16s, of); m_o16s |= of;
      acc_step(m_a16w, p, 16, 1'b0, m_a16w, of); m_o16w |= of;
      if (m_cnt < 255) m_cnt++;
      m_open = 1;
      if (last) begin
        e.s24 = m_a24; e.s16s = m_a16s; e.s16w = m_a16w;
        e.o24 = m_o24; e.o16s = m_o16s; e.o16w = m_o16w; e.beats = m_cnt;
        if (m_drop_next) m_drop_next = 0;
        else exp_q.push_back(e);
        model_reset();
      end
    end
    @(posedge CLK); #1;
    in_valid = 1'b0; in_last = 1'b0; in_clr = 1'b0;
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(posedge CLK); #1;
    end
    chk_eq("drain_pending", longint'(exp_q.size()), 0);
    drive_idle(1);
  endtask

  // Scoreboard pop on every accepted result.
  always @(negedge CLK) begin
    exp_t e;
    if (RST && v24 && out_ready) begin
      chk_eq("result_expected", longint'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk_eq("sum24", longint'(s24), e.s24);
        chk_eq("ovf24", longint'(o24), longint'(e.o24));
        chk_eq("beats24", longint'(b24), longint'(e.beats));
        chk_eq("valid16s", longint'(v16s), 1);
        chk_eq("sum16s", longint'(s16s), e.s16s);
        chk_eq("ovf16s", longint'(o16s), longint'(e.o16s));
        chk_eq("beats16s", longint'(b16s), longint'(e.beats));
        chk_eq("valid16w", longint'(v16w), 1);
        chk_eq("sum16w", longint'(s16w), e.s16w);
        chk_eq("ovf16w", longint'(o16w), longint'(e.o16w));
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, "_valid"}, longint'(v24), 0);
    chk_eq({tag, "_sum"}, longint'(s24), 0);
    chk_eq({tag, "_ovf"}, longint'(o24), 0);
    chk_eq({tag, "_beats"}, longint'(b24), 0);
    chk_eq({tag, "_drop"}, longint'({d24, d16s, d16w}), 0);
    chk_eq({tag, "_busy"}, longint'({busy24, busy16s, busy16w}), 0);
  endtask

  initial begin
    RST = 1'b0; in_valid = 0; in_last = 0; in_clr = 0; out_ready = 1'b1;
    mx = 0; my = 0; m_drop_next = 0;
    model_reset();
    #12;
    chk_reset_outputs("reset");
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;

    // Three-beat frame and result latency.
    drive_beat(3, 4, 0, 0);
    drive_beat(-5, 7, 0, 0);
    drive_beat(2, -6, 1, 0);
    chk_eq("lat_edge0", longint'(v24), 0);
    @(posedge CLK); #1;
    chk_eq("lat_edge1", longint'(v24), 0);
    @(posedge CLK); #1;
    chk_eq("lat_edge2", longint'(v24), 1);
    wait_drain();

    // Single-beat frame.
    drive_beat(-128, -128, 1, 0);
    wait_drain();

    // Overflow in 16-bit configurations.
    drive_beat(-128, -128, 0, 0);
    drive_beat(-128, -128, 1, 0);
    wait_drain();

    // Back-to-back frames, no bubbles.
    drive_beat(1, 2, 0, 0);
    drive_beat(3, 4, 1, 0);
    drive_beat(5, 6, 1, 0);
    drive_beat(7, -8, 0, 0);
    drive_beat(100, 100, 0, 0);
    drive_beat(9, 10, 1, 0);
    wait_drain();

    // Queue full: third result dropped.
    out_ready = 1'b0;
    drive_beat(1, 1, 1, 0);
    drive_beat(2, 2, 1, 0);
    m_drop_next = 1;
    drive_beat(3, 3, 1, 0);
    drive_idle(4);
    chk_eq("drop_err", longint'({d24, d16s, d16w}), 7);
    chk_eq("full_valid", longint'(v24), 1);
    chk_eq("full_head_sum", longint'(s24), 1);
    out_ready = 1'b1;
    wait_drain();
    chk_eq("drained_valid", longint'(v24), 0);

    // Abort mid-frame.
    drive_beat(1, 2, 0, 0);
    drive_beat(3, 4, 0, 0);
    drive_beat(5, 6, 0, 1);
    chk_eq("clr_busy", longint'({busy24, busy16s, busy16w}), 0);
    drive_idle(4);
    chk_eq("clr_no_result", longint'(v24), 0);
    drive_beat(1, 1, 0, 0);
    drive_beat(1, 1, 1, 0);
    wait_drain();

    // Asynchronous reset with a full queue and an open frame.
    out_ready = 1'b0;
    drive_beat(4, 4, 1, 0);
    drive_beat(5, 5, 1, 0);
    drive_beat(6, 6, 0, 0);
    drive_idle(2);
    chk_eq("pre_reset_valid", longint'(v24), 1);
    drive_beat(1, 1, 0, 0);
    #3;
    RST = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    exp_q.delete();
    model_reset();
    @(negedge CLK); @(negedge CLK);
    RST = 1'b1; out_ready = 1'b1;
    @(posedge CLK); #1;
    drive_beat(2, 3, 1, 0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mb8_psum_acc.md
# mb8_psum_acc

Partial-sum accumulator placed directly downstream of the 2-stage radix-8 Booth multiplier top (`mb8_top`). It tracks valid/last framing alongside the multiplier's operands and aligns that framing to the multiplier's fixed latency. It accumulates the signed 16-bit products of each frame into a wide accumulator. Completed sums are delivered through a 2-entry result queue with a valid/ready handshake, because the multiplier pipeline cannot be stalled.

## Interface
- `LAT`, 2: multiplier latency in cycles, from operands at `mx`/`my` to `product`.
- `PW`, 16: product width, signed two's complement.
- `ACC_W`, 24: accumulator and result width (≥ `PW`).
- `CNT_W`, 8: beat-counter width.
- `SAT`, 0: 1 = saturate on overflow, 0 = wrap.
- `CLK` input 1: clock, all logic on the rising edge.
- `RST` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: the operand pair presented to the multiplier this cycle is a valid beat.
- `in_last` input 1: that beat closes the frame. Qualified by `in_valid`.
- `in_clr` input 1: synchronous abort of the open frame and all in-flight beats.
- `product` input `PW`: multiplier output, `LAT` cycles behind the operands.
- `out_valid` output 1: head of the result queue is valid.
- `out_ready` input 1: consumer accepts the head result.
- `out_sum` output `ACC_W`: frame sum.
- `out_ovf` output 1: overflow occurred within the frame.
- `out_beats` output `CNT_W`: beats in the frame, saturating at all-ones.
- `drop_err` output 1: sticky flag, set when a result was lost because the queue was full.
- `busy` output 1: a frame is open, or a beat is in flight.

## Operation
- Delay line of `LAT` stages carries {valid, last}. The stage-`LAT` output (`v_d`, `l_d`) qualifies `product`.
- FSM has two states:
  - IDLE: no frame open. A beat with `v_d` and no `l_d` loads `acc` with sign-extended `product`, sets `cnt = 1`, and moves to ACCUM. A beat with `v_d` and `l_d` is a single-beat frame: the result is pushed and the FSM stays in IDLE.
  - ACCUM: a beat with `v_d` computes `acc + sext(product)` and increments `cnt`. If `l_d` is set, the result is pushed, `acc`, `cnt` and `ovf` are cleared, and the FSM returns to IDLE.
- Overflow is signed-add overflow in `ACC_W` bits, tracked as a sticky `ovf` per frame.
  - `SAT=1`: clamp to +max or −min and set `ovf`.
  - `SAT=0`: wrap and set `ovf`.
- Result queue holds 2 entries of {sum, ovf, beats}.
  - A pop happens when `out_valid && out_ready`.
  - A push and a pop in the same cycle are always accepted, even when the queue is full.
  - A push to a full queue with no pop discards the new result and sets `drop_err`. `drop_err` is cleared only by reset.
- `in_clr` zeroes the delay-line valid bits, `acc`, `cnt` and `ovf`, and forces IDLE. The queue is untouched. A beat presented on the same cycle as `in_clr` is also discarded.
- `busy` = (state == ACCUM) or any valid bit in the delay line.

## Timing
- Reset values: `out_valid` 0, `out_sum` 0, `out_ovf` 0, `out_beats` 0, `drop_err` 0, `busy` 0, state IDLE, queue empty, delay line cleared.
- A last beat presented at cycle t makes `out_valid` 1 at cycle t+`LAT`+1, provided the queue was empty.
- `out_*` are driven from the queue head register and hold stable while `out_valid && !out_ready`.
- Throughput is one beat per cycle with no bubbles. Back-to-back frames are allowed, including a last beat immediately followed by the next frame's first beat.
- Reset asserted mid-frame clears all state immediately. In-flight products are ignored after release.

## Structure
- Package `mb8_pkg`: `LAT`/`PW`/`ACC_W` defaults, the FSM state enum (IDLE, ACCUM), and the result-entry struct {sum, ovf, beats}.
- One sub-module, `mb8_res_fifo`: 2-entry queue with push, pop, full and empty signals.

## Test plan
- Operand frame (3,4), (−5,7), (2,−6) with last on the third beat: `out_sum` = −35, `out_beats` = 3, `out_ovf` = 0, and `out_valid` rises 3 cycles after the last beat.
- Single-beat frame (−128,−128) with last: `out_sum` = 16384, `out_beats` = 1.
- `ACC_W=16`, `SAT=1`, two beats of (−128,−128): `out_sum` = 32767, `out_ovf` = 1. With `SAT=0`: `out_sum` = −32768, `out_ovf` = 1.
- `out_ready` held at 0 for three consecutive 1-beat frames: the first two results are queued, the third is dropped and `drop_err` = 1. After draining, exactly 2 results are observed, in order.
- `in_clr` pulsed one cycle after the second beat of a 4-beat frame: no result is produced and `busy` = 0 within 1 cycle. The next frame (1,1), (1,1) with last gives `out_sum` = 2.
- `RST` low mid-frame with a full queue: all outputs return to their reset values asynchronously. After release, a new 1-beat frame (2,3) gives `out_sum` = 6.
